// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Holds the controller state encoding and the default memory-wait timeout.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2
  } state_e;

  localparam int MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        muldiv_start;
  logic        muldiv_done;
  logic        pc_pause;
  logic        if_id_pause;
  logic        if_id_bubble;
  logic        id_ex_pause;
  logic        id_ex_bubble;
  logic        ex_mem_pause;
  logic        ex_mem_bubble;
  logic        mem_wb_pause;
  logic        mem_wb_bubble;
  logic        mem_timeout;
  logic [31:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           branch_taken, mem_req, mem_ready, muldiv_start, muldiv_done,
    input  pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble,
           ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble,
           mem_timeout, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           branch_taken, mem_req, mem_ready, muldiv_start, muldiv_done,
    output pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble,
           ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble,
           mem_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_stall_counter.sv
// Saturating 32-bit event counter; holds at all-ones instead of wrapping.
module stall_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory/muldiv stalls, branch flush, load-use interlock.
// Pause/bubble outputs are combinational so they act in the same cycle.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input logic           clock,
  input logic           reset,
  hazard_ctrl_if.slave  hz
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;

  logic mem_stall;
  logic md_stall;
  logic load_use;
  logic [4:0] pause;
  logic [3:0] bubble;
  logic [31:0] stall_count;

  assign mem_stall = hz.mem_req & ~hz.mem_ready;
  assign md_stall  = (((state_q == RUN) & hz.muldiv_start) | (state_q == MD_WAIT))
                     & ~hz.muldiv_done & ~mem_stall;
  assign load_use  = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                     ((hz.id_rs1_used & (hz.id_rs1 == hz.ex_rd)) |
                      (hz.id_rs2_used & (hz.id_rs2 == hz.ex_rd)));

  // pause = {pc, if_id, id_ex, ex_mem, mem_wb}; bubble = {if_id, id_ex, ex_mem, mem_wb}
  always_comb begin
    pause  = 5'b00000;
    bubble = 4'b0000;
    if (reset) begin
      bubble = 4'b1111;
    end else if (mem_stall) begin
      pause  = 5'b11110;
      bubble = 4'b0001;
    end else if (md_stall) begin
      pause  = 5'b11100;
      bubble = 4'b0010;
    end else if (hz.branch_taken) begin
      bubble = 4'b1100;
    end else if (load_use) begin
      pause  = 5'b11000;
      bubble = 4'b0100;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else if (md_stall) begin
          state_d = MD_WAIT;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          state_d = RUN;
        end else if (mem_stall && (wait_cnt_q != TIMEOUT_VAL)) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if (wait_cnt_d == TIMEOUT_VAL) begin
            timeout_d = 1'b1;
          end
        end
      end
      // A memory freeze arriving mid-divide keeps the unit waiting
      MD_WAIT: begin
        if (hz.muldiv_done && !mem_stall) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  stall_counter u_stall_counter (
    .clock (clock),
    .reset (reset),
    .inc   (pause[4]),
    .count (stall_count)
  );

  assign hz.pc_pause      = pause[4];
  assign hz.if_id_pause   = pause[3];
  assign hz.id_ex_pause   = pause[2];
  assign hz.ex_mem_pause  = pause[1];
  assign hz.mem_wb_pause  = pause[0];
  assign hz.if_id_bubble  = bubble[3];
  assign hz.id_ex_bubble  = bubble[2];
  assign hz.ex_mem_bubble = bubble[1];
  assign hz.mem_wb_bubble = bubble[0];
  assign hz.mem_timeout   = timeout_q;
  assign hz.stall_cycles  = stall_count;

endmodule
